// File: rtl/pitch_counter.sv
// pitch_counter
// Measures the frequency of the pitch antenna oscillator by counting its
// rising edges over a fixed gate window. Each closed gate yields a raw count
// that is subtracted from a calibration offset, clamped, and smoothed by a
// first-order IIR filter to produce the pitch value for the tone generator.
// A calibration request measures one full gate and stores it as the new
// offset, so the player's "silent" hand position maps to freq = 0.
//
// Ports
//   clk        in   1       system clock, all state on the rising edge
//   reset_n    in   1       asynchronous active-low reset
//   osc_in     in   1       oscillator square wave, asynchronous to clk
//   cal        in   1       calibration request (level or pulse)
//   freq       out  F_BITS  smoothed pitch value, registered
//   freq_valid out  1       one-cycle strobe, freq updated this cycle
//   cal_busy   out  1       calibration pending or running
module pitch_counter #(
    parameter int          F_BITS      = 12,
    parameter int          CNT_BITS    = 16,
    parameter int          GATE_CYCLES = 50000,
    parameter int          SMOOTH_SH   = 2,
    parameter int unsigned OFFSET_INIT = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              osc_in,
    input  logic              cal,
    output logic [F_BITS-1:0] freq,
    output logic              freq_valid,
    output logic              cal_busy
);

    localparam int AW = F_BITS + SMOOTH_SH;
    localparam int GW = $clog2(GATE_CYCLES);

    localparam logic [GW-1:0]       G_LAST     = GW'(GATE_CYCLES - 1);
    localparam logic [GW-1:0]       G_ONE      = {{(GW-1){1'b0}}, 1'b1};
    localparam logic [CNT_BITS-1:0] CNT_MAX    = {CNT_BITS{1'b1}};
    localparam logic [CNT_BITS-1:0] CNT_ONE    = {{(CNT_BITS-1){1'b0}}, 1'b1};
    localparam logic [CNT_BITS-1:0] OFFSET_RST = CNT_BITS'(OFFSET_INIT);
    localparam logic [CNT_BITS:0]   DIFF_CAP   = (CNT_BITS+1)'((2 ** F_BITS) - 1);
    localparam logic [F_BITS-1:0]   F_MAX      = {F_BITS{1'b1}};
    localparam logic [AW-1:0]       ACC_MAX    = {AW{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_CAL_WAIT = 2'd1,
        ST_CAL_MEAS = 2'd2
    } state_t;

    // Saturating increment: the edge counter must stick at its maximum.
    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
        if (v == CNT_MAX) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_ONE;
        end
    endfunction

    logic                osc_meta_r, osc_sync_r, osc_prev_r;
    logic                rise_s;
    logic [GW-1:0]       gcnt_r;
    logic                term_s;
    logic [CNT_BITS-1:0] ecnt_r;
    logic [CNT_BITS-1:0] raw_s;
    logic [CNT_BITS-1:0] offset_r;
    logic [CNT_BITS:0]   diff_s;
    logic [F_BITS-1:0]   delta_s;
    logic [AW:0]         acc_sum_s;
    logic [AW-1:0]       acc_next_s;
    logic [AW-1:0]       acc_r;
    logic [F_BITS-1:0]   freq_r;
    logic                freq_valid_r;
    logic                cal_busy_r;
    state_t              state_r, state_next_s;
    logic                upd_s;
    logic                cal_done_s;

    // Two-flop synchronizer plus one history flop for rising-edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            osc_meta_r <= 1'b0;
            osc_sync_r <= 1'b0;
            osc_prev_r <= 1'b0;
        end else begin
            osc_meta_r <= osc_in;
            osc_sync_r <= osc_meta_r;
            osc_prev_r <= osc_sync_r;
        end
    end

    assign rise_s = osc_sync_r & ~osc_prev_r;
    assign term_s = (gcnt_r == G_LAST);

    // Free-running gate counter, 0 .. GATE_CYCLES-1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gcnt_r <= {GW{1'b0}};
        end else if (term_s) begin
            gcnt_r <= {GW{1'b0}};
        end else begin
            gcnt_r <= gcnt_r + G_ONE;
        end
    end

    // Raw count includes an edge seen in the terminal cycle itself.
    always_comb begin
        raw_s = ecnt_r;
        if (rise_s) begin
            raw_s = sat_inc(ecnt_r);
        end else begin
            raw_s = ecnt_r;
        end
    end

    // Edge counter restarts from zero after each terminal cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ecnt_r <= {CNT_BITS{1'b0}};
        end else if (term_s) begin
            ecnt_r <= {CNT_BITS{1'b0}};
        end else begin
            ecnt_r <= raw_s;
        end
    end

    // Offset minus raw, clamped into the freq range; a higher oscillator
    // frequency than the calibration point means the hand is far away.
    always_comb begin
        diff_s  = {1'b0, offset_r} - {1'b0, raw_s};
        delta_s = {F_BITS{1'b0}};
        if (diff_s[CNT_BITS]) begin
            delta_s = {F_BITS{1'b0}};
        end else if (diff_s > DIFF_CAP) begin
            delta_s = F_MAX;
        end else begin
            delta_s = diff_s[F_BITS-1:0];
        end
    end

    // IIR step: acc - acc/2^SH never underflows, so only the top needs clamping.
    always_comb begin
        acc_sum_s  = {1'b0, acc_r} + (AW+1)'(delta_s) - (AW+1)'(acc_r >> SMOOTH_SH);
        acc_next_s = acc_r;
        if (acc_sum_s[AW]) begin
            acc_next_s = ACC_MAX;
        end else begin
            acc_next_s = acc_sum_s[AW-1:0];
        end
    end

    // Next-state logic and the per-gate actions decoded from the current state.
    always_comb begin
        state_next_s = state_r;
        upd_s        = 1'b0;
        cal_done_s   = 1'b0;
        case (state_r)
            ST_RUN: begin
                upd_s = term_s;
                if (cal) begin
                    // A request in the terminal cycle lets this gate close
                    // normally and makes the very next gate the measured one.
                    state_next_s = term_s ? ST_CAL_MEAS : ST_CAL_WAIT;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_CAL_WAIT: begin
                upd_s = term_s;
                if (term_s) begin
                    state_next_s = ST_CAL_MEAS;
                end else begin
                    state_next_s = ST_CAL_WAIT;
                end
            end
            ST_CAL_MEAS: begin
                cal_done_s = term_s;
                if (term_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_CAL_MEAS;
                end
            end
            default: begin
                state_next_s = ST_RUN;
            end
        endcase
    end

    // State register with registered busy flag derived from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_RUN;
            cal_busy_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            cal_busy_r <= (state_next_s != ST_RUN);
        end
    end

    // Offset, filter and output registers, updated once per gate.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            offset_r     <= OFFSET_RST;
            acc_r        <= {AW{1'b0}};
            freq_r       <= {F_BITS{1'b0}};
            freq_valid_r <= 1'b0;
        end else begin
            freq_valid_r <= upd_s;
            if (cal_done_s) begin
                offset_r <= raw_s;
                acc_r    <= {AW{1'b0}};
                freq_r   <= {F_BITS{1'b0}};
            end else if (upd_s) begin
                acc_r  <= acc_next_s;
                freq_r <= acc_next_s[AW-1:SMOOTH_SH];
            end
        end
    end

    assign freq       = freq_r;
    assign freq_valid = freq_valid_r;
    assign cal_busy   = cal_busy_r;

endmodule
